pipeline_hazard_controller: RTL
===============================

# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage RV32IM pipeline. Drives the write enables and flushes of PC, IF/ID, ID/EX and EX/MA so the MA/WB register only ever receives retired or bubble instructions. Handles three cases: load-use hazards, multi-cycle M-extension operations in EX, and taken branches or jumps resolved in EX. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MUL_CYCLES, 2: cycles a MUL/MULH/MULHSU/MULHU occupies EX; must be ≥ 2.
- DIV_CYCLES, 33: cycles a DIV/DIVU/REM/REMU occupies EX; must be ≥ 2.

Ports:
- CLK  in  1  pipeline clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source.
- ex_memread  in  1  the EX instruction is a load.
- ex_rd  in  5  destination register of the EX instruction.
- ex_is_mul, ex_is_div  in  1 each  the EX instruction is an M-extension multiply or divide/remainder.
- branch_taken  in  1  EX has resolved a taken branch, JAL or JALR.
- pc_write, if_id_write, id_ex_write, ex_ma_write  out  1 each  stage register load enables.
- if_id_flush, id_ex_flush  out  1 each  load a NOP into that register.
- ex_ma_bubble  out  1  EX/MA loads a NOP instead of the EX result.
- mdu_start  out  1  one-cycle start pulse to the multiply/divide unit.
- mdu_result_sel  out  1  EX result mux selects the MDU output.
- mdu_busy  out  1  FSM is outside RUN.
- stall_count  out  32  number of cycles with pc_write=0 since reset.

## Operation
FSM states: RUN, MDU_BUSY, MDU_DONE. There is also a down-counter `cnt`, $clog2(DIV_CYCLES) bits wide.

- **RUN, default:** all four write enables = 1; all flushes, bubble, mdu_start and mdu_result_sel = 0.
- **RUN, (ex_is_mul | ex_is_div):**
  - mdu_start = 1, ex_ma_bubble = 1; pc_write, if_id_write and id_ex_write = 0.
  - Let N = MUL_CYCLES or DIV_CYCLES. If N == 2, go to MDU_DONE. Otherwise go to MDU_BUSY with cnt = N−3.
- **MDU_BUSY:** same freeze as above, but mdu_start = 0. If cnt == 0 go to MDU_DONE; otherwise decrement cnt.
- **MDU_DONE:** all enables = 1, mdu_result_sel = 1; go to RUN. The MDU result is captured in EX/MA and the pipeline advances, so the instruction is never re-issued.
- **RUN, load-use hazard:** triggered when ex_memread & ex_rd ≠ 0 & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
  - pc_write = 0, if_id_write = 0, id_ex_flush = 1.
  - The load advances normally. This costs exactly one bubble.
- **RUN, branch_taken:** if_id_flush = 1, id_ex_flush = 1, pc_write = 1.
- **Priority:** MDU > branch > load-use. The three conditions come from the single EX instruction and are mutually exclusive in legal streams. If inputs overlap anyway, the priority is enforced.
- **x0:** a load to x0 never creates a hazard.
- **stall_count:** increments on each edge where pc_write == 0 and RESET is low. It saturates at 0xFFFF_FFFF.

## Timing
- **During RESET:** state = RUN, cnt = 0, stall_count = 0. All write enables, flushes, ex_ma_bubble, mdu_start, mdu_result_sel and mdu_busy = 0. This freezes the pipeline.
- **First cycle after RESET deasserts:** RUN defaults apply.
- **Reset during MDU_BUSY or MDU_DONE:** immediate return to RUN. No mdu_start is re-issued after release.
- **Combinational outputs:** all outputs except stall_count are combinational from the state and the current inputs. Hazard and flush responses therefore occur in the same cycle the condition is visible.
- **MDU op:** occupies EX for exactly N cycles, consisting of 1 RUN detection cycle, N−2 MDU_BUSY cycles and 1 MDU_DONE cycle. pc_write is 0 for N−1 cycles. MA/WB receives N−1 bubbles, then the result.
- **mdu_busy:** 1 in MDU_BUSY and MDU_DONE.

## Structure
- Shared package `pipeline_ctrl_pkg` holds:
  - the state enum (RUN, MDU_BUSY, MDU_DONE);
  - default MUL_CYCLES and DIV_CYCLES constants, which are also used by the MDU.
- One combinational sub-module, `load_use_detect`. Inputs: id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_memread, ex_rd. Output: hazard.
- FSM, counter and stall counter stay in the top module.

## Test plan
- **Load-use:** ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle → pc_write=0, if_id_write=0, id_ex_flush=1 in that cycle; stall_count goes from 0 to 1. Repeat with ex_rd=0 → no stall.
- **Divide:** DIV_CYCLES=33, ex_is_div held → mdu_start pulses once, then 31 MDU_BUSY cycles, then MDU_DONE with mdu_result_sel=1. pc_write=0 for exactly 32 cycles; stall_count=32.
- **Multiply:** MUL_CYCLES=2 → RUN→MDU_DONE directly; pc_write=0 for 1 cycle; ex_ma_bubble=1 for 1 cycle.
- **Branch:** branch_taken=1 → if_id_flush=id_ex_flush=1, pc_write=1, stall_count unchanged.
- **Reset mid-divide:** RESET raised at MDU_BUSY cnt=10 → outputs immediately at reset values, stall_count=0. After release: state RUN, mdu_busy=0, no mdu_start unless ex_is_div is still asserted.
- **Saturation:** force stall_count near max via a long stall on a reduced-width build (stall_count 4-bit) → holds at 0xF after 15+ stall cycles.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the multiply/divide unit:
// FSM state encoding, default M-extension latencies and a counter-width helper.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } hc_state_e;

    localparam int MUL_CYCLES_DEF = 2;
    localparam int DIV_CYCLES_DEF = 33;

    // Wide enough for the longest MDU op's preload (N-3); never narrower than 1 bit.
    function automatic int cnt_width(input int mul_cycles, input int div_cycles);
        int longest;
        longest = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
        return (longest <= 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_load_use.sv
// Load-use hazard detector: the ID instruction reads a register that the load in EX
// has not yet produced. x0 is hard-wired to zero and never creates a hazard.
module load_use_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    output logic       hazard
);

    logic rs1_match;
    logic rs2_match;

    always_comb begin
        rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
        hazard    = ex_memread && (ex_rd != 5'd0) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline: load-use stalls, multi-cycle
// MDU freezes, taken-branch flushes, plus a saturating stall-cycle counter.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int STALL_W    = 32
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic               ex_memread,
    input  logic [4:0]         ex_rd,
    input  logic               ex_is_mul,
    input  logic               ex_is_div,
    input  logic               branch_taken,
    output logic               pc_write,
    output logic               if_id_write,
    output logic               id_ex_write,
    output logic               ex_ma_write,
    output logic               if_id_flush,
    output logic               id_ex_flush,
    output logic               ex_ma_bubble,
    output logic               mdu_start,
    output logic               mdu_result_sel,
    output logic               mdu_busy,
    output logic [STALL_W-1:0] stall_count
);

    localparam int CNT_W = cnt_width(MUL_CYCLES, DIV_CYCLES);

    // Preload values give N-2 MDU_BUSY cycles (cnt counts N-3 down to 0).
    localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_CYCLES > 2) ? CNT_W'(MUL_CYCLES - 3) : '0;
    localparam logic [CNT_W-1:0] DIV_LOAD = (DIV_CYCLES > 2) ? CNT_W'(DIV_CYCLES - 3) : '0;
    localparam logic             MUL_SHORT = (MUL_CYCLES == 2);
    localparam logic             DIV_SHORT = (DIV_CYCLES == 2);

    hc_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             hazard;
    logic             mdu_req;
    logic             mdu_short;
    logic [CNT_W-1:0] mdu_load;

    load_use_detect u_load_use (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .hazard      (hazard)
    );

    always_comb begin
        mdu_req   = ex_is_mul || ex_is_div;
        mdu_short = ex_is_mul ? MUL_SHORT : DIV_SHORT;
        mdu_load  = ex_is_mul ? MUL_LOAD : DIV_LOAD;
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        id_ex_write    = 1'b1;
        ex_ma_write    = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_ma_bubble   = 1'b0;
        mdu_start      = 1'b0;
        mdu_result_sel = 1'b0;

        case (state)
            RUN: begin
                if (mdu_req) begin
                    mdu_start    = 1'b1;
                    ex_ma_bubble = 1'b1;
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    if (mdu_short) begin
                        state_nxt = MDU_DONE;
                    end else begin
                        state_nxt = MDU_BUSY;
                        cnt_nxt   = mdu_load;
                    end
                end else if (branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (hazard) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            MDU_BUSY: begin
                ex_ma_bubble = 1'b1;
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                if (cnt == '0) begin
                    state_nxt = MDU_DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            MDU_DONE: begin
                // EX/MA captures the MDU result and the frozen stages advance together.
                mdu_result_sel = 1'b1;
                state_nxt      = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        // Reset freezes the whole pipeline, overriding the RUN defaults.
        if (RESET) begin
            pc_write       = 1'b0;
            if_id_write    = 1'b0;
            id_ex_write    = 1'b0;
            ex_ma_write    = 1'b0;
            if_id_flush    = 1'b0;
            id_ex_flush    = 1'b0;
            ex_ma_bubble   = 1'b0;
            mdu_start      = 1'b0;
            mdu_result_sel = 1'b0;
        end
    end

    assign mdu_busy = (state != RUN);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_count <= '0;
        end else if (!pc_write && (stall_count != {STALL_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule
